// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 timing constants and helpers
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam bit VGA_SYNC_POL = 1'b0;

    typedef logic [CNT_W-1:0] count_t;

    // Drive level of a sync pin: the active polarity inside the pulse, its inverse elsewhere.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with wrap, visible and sync decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = VGA_H_ACTIVE,
    parameter int FP     = VGA_H_FP,
    parameter int SYNC   = VGA_H_SYNC,
    parameter int BP     = VGA_H_BP
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    output count_t count,
    output logic   wrap,
    output logic   visible,
    output logic   sync
);

    localparam int     TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam count_t LAST       = count_t'(TOTAL - 1);
    localparam count_t ACT_END    = count_t'(ACTIVE);
    localparam count_t SYNC_START = count_t'(ACTIVE + FP);
    localparam count_t SYNC_END   = count_t'(ACTIVE + FP + SYNC - 1);

    // Wrap is qualified by the enable so the next axis can use it directly as its step.
    assign wrap    = en && (count == LAST);
    assign visible = (count < ACT_END);
    assign sync    = (count >= SYNC_START) && (count <= SYNC_END);

    // Position counter: advances only on enable, returns to 0 after the last position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + count_t'(1);
        end
    end

endmodule

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA timing generator with pixel request and one-tick colour pipeline
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit SYNC_POL = VGA_SYNC_POL
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixEn,
    input  logic [7:0] inRed,
    input  logic [7:0] inGreen,
    input  logic [7:0] inBlue,
    output logic       readEnable,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] vgaRed,
    output logic [7:0] vgaGreen,
    output logic [7:0] vgaBlue,
    output logic       blankN,
    output logic [9:0] pixelX,
    output logic [9:0] pixelY,
    output logic       frameStart
);

    count_t h_count;
    count_t v_count;
    logic   h_wrap;
    logic   h_visible;
    logic   h_sync;
    logic   v_wrap_unused;
    logic   v_visible;
    logic   v_sync;
    logic   visible0;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .en      (pixEn),
        .count   (h_count),
        .wrap    (h_wrap),
        .visible (h_visible),
        .sync    (h_sync)
    );

    // The vertical axis steps on the horizontal wrap, so the last-pixel-of-frame tick
    // returns both counters to 0 together.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .en      (h_wrap),
        .count   (v_count),
        .wrap    (v_wrap_unused),
        .visible (v_visible),
        .sync    (v_sync)
    );

    assign visible0 = h_visible && v_visible;

    // Pixel request is gated by reset so nothing is fetched while the frame is held off.
    assign readEnable = reset && pixEn && visible0;
    assign frameStart = readEnable && (h_count == '0) && (v_count == '0);

    // Stage 1: line up syncs, blanking and coordinates with the buffer's registered read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync  <= ~SYNC_POL;
            vsync  <= ~SYNC_POL;
            blankN <= 1'b0;
            pixelX <= '0;
            pixelY <= '0;
        end else if (pixEn) begin
            hsync  <= sync_level(h_sync, SYNC_POL);
            vsync  <= sync_level(v_sync, SYNC_POL);
            blankN <= visible0;
            if (visible0) begin
                pixelX <= h_count;
                pixelY <= v_count;
            end
        end
    end

    // Colour passes through only while stage 1 marks the pixel as visible.
    always_comb begin
        vgaRed   = 8'h00;
        vgaGreen = 8'h00;
        vgaBlue  = 8'h00;
        if (blankN) begin
            vgaRed   = inRed;
            vgaGreen = inGreen;
            vgaBlue  = inBlue;
        end
    end

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - self-checking bench for vga_sync_generator
module tb_vga_sync_generator;

    localparam int CLK_P = 10;

    logic clk = 1'b0;
    always #(CLK_P/2) clk = ~clk;

    logic       reset;
    logic       pixEn;
    logic [7:0] inRed;
    logic [7:0] inGreen;
    logic [7:0] inBlue;

    logic       d_re, d_hs, d_vs, d_blank, d_fs;
    logic [7:0] d_red, d_green, d_blue;
    logic [9:0] d_px, d_py;

    logic       s_re, s_hs, s_vs, s_blank, s_fs;
    logic [7:0] s_red, s_green, s_blue;
    logic [9:0] s_px, s_py;

    vga_sync_generator u_dut_def (
        .clk        (clk),
        .reset      (reset),
        .pixEn      (pixEn),
        .inRed      (inRed),
        .inGreen    (inGreen),
        .inBlue     (inBlue),
        .readEnable (d_re),
        .hsync      (d_hs),
        .vsync      (d_vs),
        .vgaRed     (d_red),
        .vgaGreen   (d_green),
        .vgaBlue    (d_blue),
        .blankN     (d_blank),
        .pixelX     (d_px),
        .pixelY     (d_py),
        .frameStart (d_fs)
    );

    vga_sync_generator #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) u_dut_small (
        .clk        (clk),
        .reset      (reset),
        .pixEn      (pixEn),
        .inRed      (inRed),
        .inGreen    (inGreen),
        .inBlue     (inBlue),
        .readEnable (s_re),
        .hsync      (s_hs),
        .vsync      (s_vs),
        .vgaRed     (s_red),
        .vgaGreen   (s_green),
        .vgaBlue    (s_blue),
        .blankN     (s_blank),
        .pixelX     (s_px),
        .pixelY     (s_py),
        .frameStart (s_fs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic pre_re_d, pre_fs_d, pre_re_s, pre_fs_s;
    time  pre_time;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One pixel tick with pixEn high for one clk out of two; combinational request
    // outputs are captured just before the active edge.
    task automatic pix_tick();
        @(negedge clk);
        pixEn = 1'b1;
        #1;
        pre_re_d = d_re;
        pre_fs_d = d_fs;
        pre_re_s = s_re;
        pre_fs_s = s_fs;
        pre_time = $time;
        @(posedge clk);
        #1;
        pixEn = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        pixEn = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       pe;
        logic       re;
        logic       fs;
        logic       blank;
        logic [9:0] px;
        logic [9:0] py;
        logic       hs;
        logic       vs;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int   re_cnt, hs_low, first_hs, blank_err, frozen_err, seq_err, re_idx, vs_low;
        logic exp_blank;
        time  t0;

        // Small instance (H 4/1/1/1 -> total 7, V 3/1/1/1 -> total 6), starting at (0,0).
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd1, 10'd0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd2, 10'd0, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd3, 10'd0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd3, 10'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd3, 10'd0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10'd3, 10'd0, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd0, 10'd1, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 10'd1, 10'd1, 1'b1, 1'b1};

        reset   = 1'b0;
        pixEn   = 1'b1;
        inRed   = 8'hFF;
        inGreen = 8'h5A;
        inBlue  = 8'h3C;

        // Reset values while held in reset with pixEn high.
        repeat (3) @(negedge clk);
        #1;
        check("rst_re",    d_re,    1'b0);
        check("rst_fs",    d_fs,    1'b0);
        check("rst_hs",    d_hs,    1'b1);
        check("rst_vs",    d_vs,    1'b1);
        check("rst_blank", d_blank, 1'b0);
        check("rst_px",    d_px,    10'd0);
        check("rst_py",    d_py,    10'd0);
        check("rst_red",   d_red,   8'h00);
        check("rst_green", d_green, 8'h00);
        check("rst_s_re",  s_re,    1'b0);

        // Table-driven vectors on the small instance.
        pixEn = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            pixEn = vecs[i].pe;
            #1;
            check($sformatf("vec%0d_re", i), s_re, vecs[i].re);
            check($sformatf("vec%0d_fs", i), s_fs, vecs[i].fs);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_blank", i), s_blank, vecs[i].blank);
            check($sformatf("vec%0d_px", i),    s_px,    vecs[i].px);
            check($sformatf("vec%0d_py", i),    s_py,    vecs[i].py);
            check($sformatf("vec%0d_hs", i),    s_hs,    vecs[i].hs);
            check($sformatf("vec%0d_vs", i),    s_vs,    vecs[i].vs);
            check($sformatf("vec%0d_red", i),   s_red,   vecs[i].blank ? 8'hFF : 8'h00);
            check($sformatf("vec%0d_blue", i),  s_blue,  vecs[i].blank ? 8'h3C : 8'h00);
        end

        // Default timing: first line, pixEn every 2nd clk.
        do_reset();
        re_cnt = 0; hs_low = 0; first_hs = -1; blank_err = 0; t0 = 0;
        for (int t = 0; t < 800; t++) begin
            pix_tick();
            if (t == 0) begin
                check("first_re", pre_re_d, 1'b1);
                check("first_fs", pre_fs_d, 1'b1);
                t0 = pre_time;
            end
            if (pre_re_d === 1'b1) re_cnt++;
            if (d_hs === 1'b0) begin
                hs_low++;
                if (first_hs < 0) first_hs = t;
            end
            exp_blank = (t < 640);
            if (d_blank !== exp_blank || d_red !== (exp_blank ? 8'hFF : 8'h00)) blank_err++;
        end
        check("line0_re_count",  re_cnt,    640);
        check("line0_hs_low",    hs_low,    96);
        check("line0_hs_first",  first_hs,  656);
        check("line0_blank_err", blank_err, 0);
        check("line0_vs",        d_vs,      1'b1);
        check("line0_py",        d_py,      10'd0);

        pix_tick();
        check("line1_re",     pre_re_d, 1'b1);
        check("line1_fs",     pre_fs_d, 1'b0);
        check("line_period",  32'(pre_time - t0), 32'(1600 * CLK_P));
        check("line1_px",     d_px, 10'd0);
        check("line1_py",     d_py, 10'd1);

        // Pause mid-line: hold pixEn low for 100 clk.
        repeat (100) pix_tick();
        check("pre_pause_px", d_px, 10'd100);
        frozen_err = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (d_re !== 1'b0 || d_px !== 10'd100 || d_py !== 10'd1 ||
                d_blank !== 1'b1 || d_hs !== 1'b1 || d_red !== 8'hFF) frozen_err++;
        end
        check("pause_frozen", frozen_err, 0);
        pix_tick();
        check("resume_re", pre_re_d, 1'b1);
        check("resume_px", d_px, 10'd101);

        // Advance to line 1, pixel 300, then reset asynchronously between edges.
        repeat (198) pix_tick();
        check("mid_px", d_px, 10'd299);
        @(posedge clk);
        #3;
        pixEn = 1'b1;
        reset = 1'b0;
        #1;
        check("async_re",    d_re,    1'b0);
        check("async_fs",    d_fs,    1'b0);
        check("async_blank", d_blank, 1'b0);
        check("async_px",    d_px,    10'd0);
        check("async_py",    d_py,    10'd0);
        check("async_hs",    d_hs,    1'b1);
        check("async_red",   d_red,   8'h00);
        @(negedge clk);
        pixEn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pix_tick();
        check("post_rst_re", pre_re_d, 1'b1);
        check("post_rst_fs", pre_fs_d, 1'b1);

        // Full small frame: 42 ticks, 12 requests in raster order, one vsync line.
        do_reset();
        seq_err = 0; re_idx = 0; vs_low = 0;
        for (int k = 0; k < 42; k++) begin
            pix_tick();
            if (pre_re_s === 1'b1) begin
                if (s_px !== 10'(re_idx % 4) || s_py !== 10'(re_idx / 4)) seq_err++;
                re_idx++;
            end
            if (s_vs === 1'b0) vs_low++;
        end
        check("small_re_count", re_idx,  12);
        check("small_seq_err",  seq_err, 0);
        check("small_vs_low",   vs_low,  7);
        pix_tick();
        check("small_wrap_fs", pre_fs_s, 1'b1);
        check("small_wrap_px", s_px, 10'd0);
        check("small_wrap_py", s_py, 10'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_generator.md
VGA_SYNC_GENERATOR -- requirements
Module: vga_sync_generator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  H_ACTIVE 640 visible pixels per line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch.
  V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33. SYNC_POL 0 sync active level (0 = active-low).
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  system clock; the block's only clock.
  reset  in  1  asynchronous, active-low reset.
  pixEn  in  1  pixel-rate tick (25 MHz from 50 MHz clk); all state advances only when high.
  inRed/inGreen/inBlue  in  8 each  pixel data from the double buffer, valid 1 pixel tick after readEnable.
  readEnable  out  1  pixel request to the double buffer, one clk wide per visible pixel.
  hsync, vsync  out  1 each  VGA sync pulses at level SYNC_POL.
  vgaRed/vgaGreen/vgaBlue  out  8 each  DAC colour, forced to 0 outside the visible area.
  blankN  out  1  high during visible pixels (aligned with the colour outputs).
  pixelX  out  10  visible column; pixelY  out  10  visible line (aligned with the colour outputs).
  frameStart  out  1  one-clk pulse when pixel (0,0) is requested.

Function
REQ-003 hCount SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters) on each pixEn and wrap to 0.
REQ-004 vCount SHALL increment on an hCount wrap and itself wrap to 0 after V_TOTAL-1.
REQ-005 Stage 0 visible condition: hCount < H_ACTIVE and vCount < V_ACTIVE.
REQ-006 readEnable SHALL be combinational: stage-0 visible AND pixEn.
REQ-007 Exactly H_ACTIVE*V_ACTIVE readEnable pulses SHALL occur per frame.
REQ-008 frameStart SHALL equal readEnable AND hCount==0 AND vCount==0.
REQ-009 hsync SHALL be asserted for stage-0 hCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
REQ-010 vsync SHALL be asserted for stage-0 vCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
REQ-011 Stage 1: hsync, vsync, blankN, pixelX and pixelY SHALL be registered on pixEn.
  - This gives 1 pixel tick of latency and matches the double buffer's registered read.
REQ-012 vgaRed/vgaGreen/vgaBlue SHALL equal inRed/inGreen/inBlue when stage-1 blankN=1, else 8'h00.
  - The colour path is combinational from stage-1 blankN.
REQ-013 pixelX/pixelY SHALL hold their last visible value while blanked.
REQ-014 When pixEn=0, all registers SHALL hold and readEnable SHALL be 0.
REQ-015 Counter widths SHALL be 10 bits; the parameters SHALL satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024.
REQ-016 The final line wrap (hCount=H_TOTAL-1, vCount=V_TOTAL-1) SHALL move both counters to 0 in the same tick.

Reset
REQ-017 While reset=0: counters, pixelX, pixelY and blankN SHALL be 0; hsync and vsync SHALL be deasserted (~SYNC_POL).
REQ-018 While reset=0: readEnable, frameStart and the colour outputs SHALL be 0.
REQ-019 Asserting reset mid-frame SHALL abort the frame immediately.
REQ-020 After reset release, the first pixEn SHALL request pixel (0,0) with frameStart.

Structure
REQ-021 The 640x480@60 timing constants and H_TOTAL/V_TOTAL SHALL live in a shared package, vga_timing_pkg, reused by the double buffer and the top level.
REQ-022 One sub-module, vga_axis_counter, SHALL be instantiated twice (horizontal and vertical).
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Ports: count enable, wrap output, visible output, sync output.

Verification
REQ-023 Reset release, default parameters, pixEn every 2nd clk -> line period = 1600 clk; frame = 800*525 pixEn ticks; first readEnable coincides with frameStart.
REQ-024 Full frame -> exactly 307200 readEnable pulses; hsync low for 96 ticks starting at tick 656 of each line; vsync low on lines 490-491.
REQ-025 Drive inRed=8'hFF constantly -> vgaRed=8'hFF only when blankN=1, 8'h00 in the porches; first blankN rises 1 tick after the first readEnable.
REQ-026 Hold pixEn=0 for 100 clk mid-line -> counters, syncs and outputs frozen; no readEnable; resume at the same hCount.
REQ-027 Assert reset at line 200, pixel 300 -> all outputs reach reset values asynchronously; after release, frameStart occurs on the first pixEn.
REQ-028 Small parameters (H 4/1/1/1, V 3/1/1/1) -> wrap at hCount 6 and vCount 5; 12 readEnables per frame; pixelX/pixelY sequence 0..3 x 0..2.
